// File: rtl/flt_job_ctrl.sv
// rtl/flt_job_ctrl.sv - flt2int job sequencer: loads operands, starts the core, streams results back
// Optional watchdog on the core wait is enabled by defining FLT_JOB_WATCHDOG_EN.
module flt_job_ctrl #(
    parameter int IN_BASE     = 0,
    parameter int IN_LEN      = 2,
    parameter int OUT_BASE    = 5,
    parameter int OUT_LEN     = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] dm_addr,
    output logic       dm_wr,
    output logic       dm_rd,
    output logic [7:0] dm_wdata,
    input  logic [7:0] dm_rdata,
    output logic       core_start,
    input  logic       core_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RDREQ, RDCAP, DRAIN} state_t;

    localparam logic [3:0] IN_LAST  = 4'(IN_LEN - 1);
    localparam logic [3:0] OUT_LAST = 4'(OUT_LEN - 1);

    state_t     state;
    logic [3:0] in_idx;
    logic [3:0] out_idx;
    logic       in_fire;
    logic [7:0] in_addr;
    logic [7:0] rd_addr;

    // Reset gating keeps the accept path quiet while reset is held.
    assign in_ready   = !reset && (state == IDLE || state == LOAD);
    assign in_fire    = in_valid && in_ready;
    assign in_addr    = 8'(IN_BASE) + {4'd0, in_idx};
    assign rd_addr    = 8'(OUT_BASE) + {4'd0, out_idx};
    assign dm_wr      = in_fire;
    assign dm_rd      = !reset && (state == RDREQ);
    assign dm_wdata   = in_fire ? in_data : 8'd0;
    assign dm_addr    = in_fire ? in_addr : (dm_rd ? rd_addr : 8'd0);
    assign core_start = (state == START);
    assign out_valid  = (state == DRAIN);
    assign busy       = (state != IDLE);

`ifdef FLT_JOB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_idx   <= 4'd0;
            out_idx  <= 4'd0;
            out_data <= 8'd0;
`ifdef FLT_JOB_WATCHDOG_EN
            err      <= 1'b0;
            wd_cnt   <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
`ifdef FLT_JOB_WATCHDOG_EN
                        err <= 1'b0;
`endif
                        if (IN_LAST == 4'd0) begin
                            state <= START;
                        end else begin
                            in_idx <= 4'd1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        if (in_idx == IN_LAST) begin
                            in_idx <= 4'd0;
                            state  <= START;
                        end else begin
                            in_idx <= in_idx + 4'd1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef FLT_JOB_WATCHDOG_EN
                    wd_cnt <= 16'd0;
`endif
                end
                WAIT: begin
                    // core_done wins over a timeout landing in the same cycle.
                    if (core_done) begin
                        out_idx <= 4'd0;
                        state   <= RDREQ;
`ifdef FLT_JOB_WATCHDOG_EN
                    end else if (wd_cnt == WD_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
`endif
                    end
                end
                RDREQ: state <= RDCAP;
                RDCAP: begin
                    out_data <= dm_rdata;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx == OUT_LAST) begin
                            state <= IDLE;
                        end else begin
                            out_idx <= out_idx + 4'd1;
                            state   <= RDREQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flt_job_ctrl.sv
// tb/tb_flt_job_ctrl.sv - self-checking bench for flt_job_ctrl with a memory/core model
module tb_flt_job_ctrl;

    localparam int IN_BASE  = 0;
    localparam int IN_LEN   = 2;
    localparam int OUT_BASE = 5;
    localparam int OUT_LEN  = 2;
`ifdef FLT_JOB_WATCHDOG_EN
    localparam int TIMEOUT_CYC = 8;
`else
    localparam int TIMEOUT_CYC = 1023;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] dm_addr;
    logic       dm_wr;
    logic       dm_rd;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;
    logic       core_start;
    logic       core_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       err;

    int checks = 0;
    int passed = 0;

    flt_job_ctrl #(
        .IN_BASE(IN_BASE), .IN_LEN(IN_LEN), .OUT_BASE(OUT_BASE),
        .OUT_LEN(OUT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_rd(dm_rd),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .core_start(core_start),
        .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory and bus log, sampled mid-cycle; read data appears only one cycle after dm_rd.
    logic [7:0] core_mem [256];
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q  [$];
    logic [7:0] rd_addr_q [$];
    int         start_cyc_q [$];
    logic [7:0] out_q [$];
    int         both_hi = 0;
    int         cyc = 0;

    initial begin
        bit         rd_pend;
        logic [7:0] rd_a;
        rd_pend = 1'b0;
        rd_a = 8'd0;
        dm_rdata = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_pend) dm_rdata = core_mem[rd_a];
            else         dm_rdata = 8'($urandom);
            rd_pend = 1'b0;
            if (dm_wr && dm_rd) both_hi++;
            if (dm_wr) begin
                wr_addr_q.push_back(dm_addr);
                wr_data_q.push_back(dm_wdata);
                wr_cyc_q.push_back(cyc);
            end
            if (dm_rd) begin
                rd_addr_q.push_back(dm_addr);
                rd_pend = 1'b1;
                rd_a = dm_addr;
            end
            if (core_start) start_cyc_q.push_back(cyc);
            if (out_valid && out_ready) out_q.push_back(out_data);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); start_cyc_q.delete(); out_q.delete();
    endtask

    task automatic send_bytes(input logic [7:0] b [16], input int n, input bit gaps, output bit to);
        int  i = 0;
        int  g = 0;
        bit  fire;
        to = 1'b0;
        while (i < n && !to) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = b[i];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            g++;
            if (g > 200) to = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_core(input int dly, input logic [7:0] rb [16], output bit to);
        int g = 0;
        while (!core_start && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        to = !core_start;
        for (int j = 0; j < OUT_LEN; j++) core_mem[8'(OUT_BASE + j)] = rb[j];
        repeat (dly) begin @(posedge clk); #1; end
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    task automatic drain(input bit rnd, output bit to);
        int g = 0;
        while (busy && g < 500) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            g++;
        end
        out_ready = 1'b0;
        to = busy;
    endtask

    task automatic run_job(input logic [7:0] ib [16], input logic [7:0] rb [16],
                           input int dly, input bit rnd, output bit to);
        bit t1, t2, t3;
        send_bytes(ib, IN_LEN, rnd, t1);
        run_core(dly, rb, t2);
        drain(rnd, t3);
        to = t1 | t2 | t3;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hA5; core_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, dm_wr, dm_rd, core_start, out_valid, busy, err} !== 7'd0)
            $display("FAIL reset_ctrl: got %b want 0000000", {in_ready, dm_wr, dm_rd, core_start, out_valid, busy, err});
        else passed++;
        checks++;
        if ({dm_addr, dm_wdata, out_data} !== 24'd0)
            $display("FAIL reset_data: got %h want 000000", {dm_addr, dm_wdata, out_data});
        else passed++;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_first_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_job();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit to;
        foreach (ib[i]) begin ib[i] = 8'd0; rb[i] = 8'd0; end
        ib[0] = 8'h3F; ib[1] = 8'hC0; rb[0] = 8'h12; rb[1] = 8'h34;
        clear_logs();
        run_job(ib, rb, 10, 1'b0, to);
        checks++;
        if (to) $display("FAIL basic_timeout: job did not complete, busy=%b", busy); else passed++;
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'd0 || wr_addr_q[1] !== 8'd1 ||
            wr_data_q[0] !== 8'h3F || wr_data_q[1] !== 8'hC0)
            $display("FAIL basic_writes: got %0d writes first %h=%h, want 00=3f 01=c0",
                     wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : 8'hxx,
                     wr_data_q.size() > 0 ? wr_data_q[0] : 8'hxx);
        else passed++;
        checks++;
        if (wr_cyc_q.size() != 2 || wr_cyc_q[1] != wr_cyc_q[0] + 1)
            $display("FAIL basic_write_spacing: writes not on consecutive cycles (%0d writes)", wr_cyc_q.size());
        else passed++;
        checks++;
        if (start_cyc_q.size() != 1 || wr_cyc_q.size() != 2 || start_cyc_q[0] != wr_cyc_q[1] + 1)
            $display("FAIL basic_start: got %0d start cycles, want exactly 1 right after last write", start_cyc_q.size());
        else passed++;
        checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 8'd5 || rd_addr_q[1] !== 8'd6)
            $display("FAIL basic_reads: got %0d reads, want addr 5 then 6", rd_addr_q.size());
        else passed++;
        checks++;
        if (out_q.size() != 2 || out_q[0] !== 8'h12 || out_q[1] !== 8'h34)
            $display("FAIL basic_out: got %0d bytes first %h, want 12 34",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 8'hxx);
        else passed++;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) $display("FAIL basic_idle: got busy=%b err=%b want 0 0", busy, err);
        else passed++;
    endtask

    task automatic test_drain_stall();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit t1, t2, t3;
        int g = 0;
        int bad = 0;
        int rd0;
        foreach (ib[i]) begin ib[i] = 8'(i + 1); rb[i] = 8'd0; end
        rb[0] = 8'h12; rb[1] = 8'h34;
        clear_logs();
        out_ready = 1'b0;
        send_bytes(ib, IN_LEN, 1'b0, t1);
        run_core(3, rb, t2);
        while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
        rd0 = rd_addr_q.size();
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 8'h12) bad++;
        end
        checks++;
        if (bad != 0 || t1 || t2) $display("FAIL stall_hold: got %0d bad cycles (out_data=%h), want 0", bad, out_data);
        else passed++;
        checks++;
        if (rd_addr_q.size() != rd0 || rd0 != 1)
            $display("FAIL stall_no_read: got %0d reads, want 1", rd_addr_q.size());
        else passed++;
        drain(1'b0, t3);
        checks++;
        if (t3 || out_q.size() != 2 || out_q[0] !== 8'h12 || out_q[1] !== 8'h34)
            $display("FAIL stall_out: got %0d bytes timeout=%b, want 12 34", out_q.size(), t3);
        else passed++;
    endtask

    task automatic test_reset_mid_job();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit t1, to;
        int g = 0;
        foreach (ib[i]) begin ib[i] = 8'(8'h40 + i); rb[i] = 8'(8'h90 + i); end
        clear_logs();
        send_bytes(ib, IN_LEN, 1'b0, t1);
        while (!core_start && g < 20) begin @(posedge clk); #1; g++; end
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, dm_wr, dm_rd, core_start, out_valid, busy, err} !== 7'd0 ||
            {dm_addr, dm_wdata, out_data} !== 24'd0)
            $display("FAIL midreset_outputs: got ctrl=%b data=%h want 0", {in_ready, dm_wr, dm_rd, core_start, out_valid, busy, err},
                     {dm_addr, dm_wdata, out_data});
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0 || rd_addr_q.size() != 0 || t1)
            $display("FAIL midreset_done_ignored: got busy=%b reads=%0d want 0 0", busy, rd_addr_q.size());
        else passed++;
        clear_logs();
        run_job(ib, rb, 2, 1'b0, to);
        checks++;
        if (to || out_q.size() != 2 || out_q[0] !== 8'h90 || out_q[1] !== 8'h91)
            $display("FAIL midreset_new_job: got %0d bytes timeout=%b, want 90 91", out_q.size(), to);
        else passed++;
    endtask

    task automatic test_done_in_load();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit t1, t2, t3;
        foreach (ib[i]) begin ib[i] = 8'd0; rb[i] = 8'(8'hE0 + i); end
        clear_logs();
        in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        core_done = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || start_cyc_q.size() != 0 || rd_addr_q.size() != 0)
            $display("FAIL load_done_ignored: got busy=%b ready=%b starts=%0d reads=%0d want 1 1 0 0",
                     busy, in_ready, start_cyc_q.size(), rd_addr_q.size());
        else passed++;
        core_done = 1'b0;
        ib[0] = 8'h88;
        send_bytes(ib, 1, 1'b0, t1);
        run_core(1, rb, t2);
        drain(1'b0, t3);
        checks++;
        if (t1 || t2 || t3 || start_cyc_q.size() != 1 || wr_cyc_q.size() != 2 ||
            start_cyc_q[0] != wr_cyc_q[1] + 1 || out_q.size() != 2 || out_q[0] !== 8'hE0 || out_q[1] !== 8'hE1)
            $display("FAIL load_start_after_last: got starts=%0d writes=%0d outs=%0d, want 1 2 2",
                     start_cyc_q.size(), wr_cyc_q.size(), out_q.size());
        else passed++;
    endtask

    task automatic test_random_jobs();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit to;
        bit bad_w, bad_r, bad_o;
        for (int it = 0; it < 12; it++) begin
            foreach (ib[i]) begin ib[i] = 8'($urandom); rb[i] = 8'($urandom); end
            clear_logs();
            run_job(ib, rb, $urandom_range(0, 15), 1'b1, to);
            bad_w = (wr_addr_q.size() != IN_LEN);
            if (!bad_w)
                for (int k = 0; k < IN_LEN; k++)
                    if (wr_addr_q[k] !== 8'((IN_BASE + k) % 256) || wr_data_q[k] !== ib[k]) bad_w = 1'b1;
            bad_r = (rd_addr_q.size() != OUT_LEN);
            if (!bad_r)
                for (int k = 0; k < OUT_LEN; k++)
                    if (rd_addr_q[k] !== 8'((OUT_BASE + k) % 256)) bad_r = 1'b1;
            bad_o = (out_q.size() != OUT_LEN);
            if (!bad_o)
                for (int k = 0; k < OUT_LEN; k++)
                    if (out_q[k] !== rb[k]) bad_o = 1'b1;
            checks++;
            if (bad_w || to) $display("FAIL rand_writes it%0d: got %0d writes timeout=%b, want %0d", it, wr_addr_q.size(), to, IN_LEN);
            else passed++;
            checks++;
            if (bad_r) $display("FAIL rand_reads it%0d: got %0d reads, want %0d from %0d", it, rd_addr_q.size(), OUT_LEN, OUT_BASE);
            else passed++;
            checks++;
            if (bad_o) $display("FAIL rand_out it%0d: got %0d bytes first %h, want first %h", it, out_q.size(),
                                out_q.size() > 0 ? out_q[0] : 8'hxx, rb[0]);
            else passed++;
        end
        checks++;
        if (both_hi != 0) $display("FAIL rd_wr_exclusive: got %0d overlapping cycles, want 0", both_hi);
        else passed++;
    endtask

`ifdef FLT_JOB_WATCHDOG_EN
    task automatic test_watchdog();
        logic [7:0] ib [16];
        logic [7:0] rb [16];
        bit t1, t2, t3;
        int g = 0;
        int n = 0;
        foreach (ib[i]) begin ib[i] = 8'(i); rb[i] = 8'(8'hC0 + i); end
        clear_logs();
        send_bytes(ib, IN_LEN, 1'b0, t1);
        while (!core_start && g < 20) begin @(posedge clk); #1; g++; end
        while (err !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != TIMEOUT_CYC + 1 || busy !== 1'b0 || rd_addr_q.size() != 0 || t1)
            $display("FAIL wd_timeout: got err after %0d edges busy=%b reads=%0d, want %0d 0 0",
                     n, busy, rd_addr_q.size(), TIMEOUT_CYC + 1);
        else passed++;
        in_valid = 1'b1; in_data = ib[0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b0) $display("FAIL wd_clear: got err=%b want 0", err);
        else passed++;
        ib[0] = ib[1];
        send_bytes(ib, 1, 1'b0, t1);
        run_core(2, rb, t2);
        drain(1'b0, t3);
        checks++;
        if (t1 || t2 || t3 || err !== 1'b0 || out_q.size() != 2 || out_q[0] !== 8'hC0)
            $display("FAIL wd_recover: got outs=%0d err=%b, want 2 0", out_q.size(), err);
        else passed++;
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; core_done = 1'b0; out_ready = 1'b0;
        foreach (core_mem[i]) core_mem[i] = 8'd0;
        test_reset();
        test_basic_job();
        test_drain_stall();
        test_reset_mid_job();
        test_done_in_load();
        test_random_jobs();
`ifdef FLT_JOB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/flt_job_ctrl.md
FLT_JOB_CTRL -- requirements
Module: flt_job_ctrl

Interface
REQ-001 Parameter IN_BASE, 0: data-memory address of first operand byte.
REQ-002 Parameter IN_LEN, 2: operand bytes per job, range 1..16.
REQ-003 Parameter OUT_BASE, 5: data-memory address of first result byte.
REQ-004 Parameter OUT_LEN, 2: result bytes per job, range 1..16.
REQ-005 Parameter TIMEOUT_CYC, 1023: watchdog limit in cycles, range 1..65535.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  operand byte offered.
REQ-009 in_ready  output  1  operand byte accepted when in_valid and in_ready are both high.
REQ-010 in_data  input  8  operand byte.
REQ-011 dm_addr  output  8  data-memory address.
REQ-012 dm_wr  output  1  data-memory write strobe.
REQ-013 dm_rd  output  1  data-memory read strobe.
REQ-014 dm_wdata  output  8  data-memory write data.
REQ-015 dm_rdata  input  8  data-memory read data, valid one cycle after dm_rd.
REQ-016 core_start  output  1  start pulse to the flt2int core.
REQ-017 core_done  input  1  core completion level.
REQ-018 out_valid  output  1  result byte offered.
REQ-019 out_ready  input  1  result byte consumed when out_valid and out_ready are both high.
REQ-020 out_data  output  8  result byte.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 err  output  1  sticky watchdog-timeout flag.

Function
REQ-023 States: IDLE, LOAD, START, WAIT, RDREQ, RDCAP, DRAIN.
REQ-024 in_ready high in IDLE and LOAD only.
REQ-025 Each accepted byte k (0-based) drives dm_wr=1, dm_addr=IN_BASE+k, dm_wdata=in_data combinationally in the accept cycle.
REQ-026 The first accept in IDLE moves to LOAD and clears err; the accept of byte IN_LEN-1 moves to START (IN_LEN=1: IDLE goes directly to START).
REQ-027 START lasts one cycle with core_start=1, then WAIT; core_start is 0 in all other states.
REQ-028 WAIT exits on core_done=1 to RDREQ with read index j=0; core_done is ignored in all other states.
REQ-029 RDREQ: dm_rd=1, dm_addr=OUT_BASE+j for one cycle, then RDCAP.
REQ-030 RDCAP: register dm_rdata into out_data, then DRAIN.
REQ-031 DRAIN: out_valid=1; out_data held stable until handshake.
REQ-032 DRAIN handshake: j<OUT_LEN-1 increments j and moves to RDREQ; otherwise moves to IDLE.
REQ-033 Minimum cost per result byte: 3 cycles (RDREQ, RDCAP, DRAIN with out_ready=1).
REQ-034 Address arithmetic is 8-bit and wraps modulo 256.
REQ-035 dm_wr and dm_rd are never both high; both are 0 outside the states named above.
REQ-036 in_valid low in LOAD stalls without timeout; out_ready low in DRAIN stalls indefinitely.

Reset
REQ-037 Reset asserted at any time, including mid-job: state IDLE, counters 0, out_data 0, err 0.
REQ-038 During reset: in_ready, dm_wr, dm_rd, core_start, out_valid and busy are 0; dm_addr and dm_wdata are 0.
REQ-039 First in_ready=1 occurs in the first cycle after reset deasserts.

Configuration
REQ-040 Macro FLT_JOB_WATCHDOG_EN defined: a 16-bit counter runs in WAIT.
REQ-041 With FLT_JOB_WATCHDOG_EN: if the counter reaches TIMEOUT_CYC without core_done, set err=1, skip readout and return to IDLE.
REQ-042 Without FLT_JOB_WATCHDOG_EN: no counter; WAIT holds until core_done; err is tied 0.

Verification
REQ-043 Reset, then bytes 0x3F,0xC0 with in_valid held -> dm writes addr0=0x3F, addr1=0xC0 on consecutive cycles; core_start one cycle later, high for exactly 1 cycle.
REQ-044 core_done pulsed 10 cycles after core_start, dm_rdata 0x12 then 0x34 -> dm_rd at addr5 then addr6; out_data 0x12 then 0x34; then IDLE with busy=0.
REQ-045 out_ready held low 20 cycles in DRAIN -> out_valid stays 1, out_data=0x12 unchanged, no dm_rd issued.
REQ-046 Reset asserted in WAIT -> all outputs 0 next cycle; subsequent core_done ignored; new job accepted normally.
REQ-047 FLT_JOB_WATCHDOG_EN defined, TIMEOUT_CYC=8, core_done never asserted -> err=1 after 8 WAIT cycles, no dm_rd, IDLE; next accepted byte clears err.
REQ-048 core_done high during LOAD -> no effect; core_start still issued only after byte IN_LEN-1.
